// File: rtl/char_plotter_if.sv
// Request, decoder and frame-buffer signals of the character plotter.
interface char_plotter_if #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3
);
   logic                req_valid;
   logic                req_ready;
   logic [6:0]          req_code;
   logic [4:0]          req_col;
   logic [2:0]          req_row;
   logic [COLOUR_W-1:0] req_fg;
   logic [COLOUR_W-1:0] req_bg;
   logic [6:0]          dec_code;
   logic [127:0]        dec_glyph;
   logic [X_W-1:0]      vga_x;
   logic [Y_W-1:0]      vga_y;
   logic [COLOUR_W-1:0] vga_colour;
   logic                vga_plot;
   logic                busy;
   logic                done;

   // Requester side: issues requests, supplies decoded glyphs, consumes plots.
   modport master (
      output req_valid, req_code, req_col, req_row, req_fg, req_bg, dec_glyph,
      input  req_ready, dec_code, vga_x, vga_y, vga_colour, vga_plot, busy, done
   );

   // Plotter side.
   modport slave (
      input  req_valid, req_code, req_col, req_row, req_fg, req_bg, dec_glyph,
      output req_ready, dec_code, vga_x, vga_y, vga_colour, vga_plot, busy, done
   );
endinterface

// File: rtl/char_plotter.sv
// Character plotter: accepts one character request, fetches its 8x16 glyph
// from an external combinational decoder and writes it pixel by pixel.
module char_plotter #(
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int COLOUR_W    = 3,
   parameter bit TRANSPARENT = 1'b0
) (
   input  logic clock,
   input  logic resetn,
   char_plotter_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DRAW = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]          state;
   logic [4:0]          col;
   logic [2:0]          row;
   logic [COLOUR_W-1:0] fg;
   logic [COLOUR_W-1:0] bg;
   logic [127:0]        glyph;
   logic [2:0]          px;
   logic [3:0]          py;
   logic                done_q;
   logic [6:0]          dec_code_q;
   logic [X_W-1:0]      x_q;
   logic [Y_W-1:0]      y_q;
   logic [COLOUR_W-1:0] colour_q;
   logic                plot_q;

   logic [6:0]          bit_idx;
   logic                pix_bit;
   logic [X_W-1:0]      x_base;
   logic [Y_W-1:0]      y_base;

   // Pixel k = {py,px} lives at glyph[127-k], i.e. at the bitwise inverse of k.
   assign bit_idx = ~{py, px};
   assign pix_bit = glyph[bit_idx];
   assign x_base  = X_W'({col, 3'b000});
   assign y_base  = Y_W'({row, 4'b0000});

   // Request sequencing, glyph walk and registered pixel outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         fg         <= '0;
         bg         <= '0;
         glyph      <= '0;
         px         <= '0;
         py         <= '0;
         done_q     <= 1'b0;
         dec_code_q <= '0;
         x_q        <= '0;
         y_q        <= '0;
         colour_q   <= '0;
         plot_q     <= 1'b0;
      end else begin
         plot_q <= 1'b0;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  col        <= bus.req_col;
                  row        <= bus.req_row;
                  fg         <= bus.req_fg;
                  bg         <= bus.req_bg;
                  dec_code_q <= bus.req_code;
                  if (bus.req_col > 5'd19 || bus.req_row > 3'd6)
                     state <= DONE;
                  else
                     state <= LOAD;
               end
            end
            LOAD: begin
               glyph <= bus.dec_glyph;
               px    <= '0;
               py    <= '0;
               state <= DRAW;
            end
            DRAW: begin
               x_q      <= x_base + X_W'(px);
               y_q      <= y_base + Y_W'(py);
               colour_q <= pix_bit ? fg : bg;
               plot_q   <= TRANSPARENT ? pix_bit : 1'b1;
               px       <= px + 3'd1;
               if (px == 3'd7)
                  py <= py + 4'd1;
               if (px == 3'd7 && py == 4'd15)
                  state <= DONE;
            end
            default: begin
               // DONE spans two cycles: the first lets the last pixel show,
               // the second carries the done pulse.
               if (!done_q)
                  done_q <= 1'b1;
               else
                  state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.done       = done_q;
   assign bus.dec_code   = dec_code_q;
   assign bus.vga_x      = x_q;
   assign bus.vga_y      = y_q;
   assign bus.vga_colour = colour_q;
   assign bus.vga_plot   = plot_q;

endmodule
